// File: rtl/fetch_seq_ctrl.sv
// Fetch-PC sequencer driving the IF/IS latch enable/flush and the imem request handshake.
// Latch/request controls respond in the same cycle as their inputs; PC, state and stats update on the next edge.
// Issue back-pressure parks the fetcher in HOLD; slow imem parks it in WAIT; redirects pre-empt both.
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   imem_ready,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    output logic [31:0]            pc_out,
    output logic                   latch_en,
    output logic                   latch_flush,
    output logic [1:0]             fsm_state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // The bubble counter holds at most FLUSH_CYCLES-1; keep it at least one bit wide.
    localparam int              BC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [BC_W-1:0] BC_RELOAD = BC_W'(FLUSH_CYCLES - 1);
    localparam logic [31:0]     PC_ALIGN  = 32'hFFFF_FFFC;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [BC_W-1:0]        bc_q, bc_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic req_c;
    logic en_c;
    logic flush_c;

    // Next-state and same-cycle control decode; priority is rst > redirect > issue_stall > imem_ready.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bc_d    = bc_q;
        req_c   = 1'b0;
        en_c    = 1'b0;
        flush_c = 1'b0;

        if (rst) begin
            // Any outstanding request is abandoned and a same-cycle ready is ignored.
            state_d = ST_FETCH;
            pc_d    = RESET_PC;
            bc_d    = '0;
        end else if (redirect) begin
            // Overwrite the wrong-path word in IS with a bubble and drop any returning data.
            en_c    = 1'b1;
            flush_c = 1'b1;
            pc_d    = redirect_pc & PC_ALIGN;
            bc_d    = BC_RELOAD;
            state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_FETCH;
        end else begin
            unique case (state_q)
                ST_FETCH, ST_WAIT: begin
                    // WAIT keeps the same address on the bus until imem answers.
                    req_c = 1'b1;
                    if (imem_ready && issue_stall) begin
                        // Data is discarded; the same word is refetched once IS frees up.
                        state_d = ST_HOLD;
                    end else if (imem_ready) begin
                        en_c    = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    // No request while parked, so nothing can be in flight when we resume.
                    if (!issue_stall) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FLUSH: begin
                    en_c    = 1'b1;
                    flush_c = 1'b1;
                    if (bc_q != '0) begin
                        bc_d = bc_q - 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // Stall statistic: count every non-reset cycle where the latch does not load, saturating.
    always_comb begin
        stall_d = stall_q;
        if (rst) begin
            stall_d = '0;
        end else if (!en_c && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State, PC, bubble counter and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            bc_q    <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bc_q    <= bc_d;
            stall_q <= stall_d;
        end
    end

    assign imem_req     = req_c;
    assign latch_en     = en_c;
    assign latch_flush  = flush_c;
    assign imem_addr    = pc_q;
    assign pc_out       = pc_q;
    assign fsm_state    = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed scenarios followed by random traffic.
// Expected per-cycle outputs are queued at drive time and compared mid-cycle.
// Includes redirect, stall, slow-memory, reset-in-WAIT and PC wrap cases.
module tb_fetch_seq_ctrl;

    localparam int SCW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_stall = 1'b0;
    logic            redirect = 1'b0;
    logic [31:0]     redirect_pc = 32'h0;
    logic            imem_ready = 1'b0;
    logic            imem_req;
    logic [31:0]     imem_addr;
    logic [31:0]     pc_out;
    logic            latch_en;
    logic            latch_flush;
    logic [1:0]      fsm_state;
    logic [SCW-1:0]  stall_cycles;

    fetch_seq_ctrl #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2),
        .STALL_CNT_W  (SCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_stall  (issue_stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc_out       (pc_out),
        .latch_en     (latch_en),
        .latch_flush  (latch_flush),
        .fsm_state    (fsm_state),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           regs_ok;
        logic           req;
        logic [31:0]    pc;
        logic           en;
        logic           fl;
        logic [1:0]     st;
        logic [SCW-1:0] sc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [1:0]     m_st;
    logic [31:0]    m_pc;
    int             m_bc;
    logic [SCW-1:0] m_sc;
    logic           m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected outputs, advance the model.
    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] rp, input logic rdy);
        exp_t e;
        logic [1:0]  n_st;
        logic [31:0] n_pc;
        int          n_bc;
        @(negedge clk);
        rst = r; issue_stall = s; redirect = rd; redirect_pc = rp; imem_ready = rdy;

        e.regs_ok = m_valid;
        e.pc = m_pc; e.st = m_st; e.sc = m_sc;
        e.req = 1'b0; e.en = 1'b0; e.fl = 1'b0;
        n_st = m_st; n_pc = m_pc; n_bc = m_bc;
        if (r) begin
            n_st = 2'd0; n_pc = 32'h0; n_bc = 0;
        end else if (rd) begin
            e.en = 1'b1; e.fl = 1'b1;
            n_pc = {rp[31:2], 2'b00};
            n_bc = 1;
            n_st = 2'd3;
        end else begin
            case (m_st)
                2'd0, 2'd1: begin
                    e.req = 1'b1;
                    if (rdy && s)  n_st = 2'd2;
                    else if (rdy) begin e.en = 1'b1; n_pc = m_pc + 32'd4; n_st = 2'd0; end
                    else          n_st = 2'd1;
                end
                2'd2: if (!s) n_st = 2'd0;
                default: begin
                    e.en = 1'b1; e.fl = 1'b1;
                    if (m_bc > 0) n_bc = m_bc - 1;
                    else          n_st = 2'd0;
                end
            endcase
        end
        sb_q.push_back(e);

        if (r)                               m_sc = '0;
        else if (!e.en && m_sc != '1)        m_sc = m_sc + 1'b1;
        m_st = n_st; m_pc = n_pc; m_bc = n_bc;
        m_valid = 1'b1;
    endtask

    // Scoreboard consumer: compare the queued expectation against the settled DUT outputs.
    always begin
        @(negedge clk);
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("imem_req",    {31'b0, imem_req},    {31'b0, mon_e.req});
            chk("latch_en",    {31'b0, latch_en},    {31'b0, mon_e.en});
            chk("latch_flush", {31'b0, latch_flush}, {31'b0, mon_e.fl});
            if (mon_e.regs_ok) begin
                chk("imem_addr",    imem_addr,            mon_e.pc);
                chk("pc_out",       pc_out,               mon_e.pc);
                chk("fsm_state",    {30'b0, fsm_state},   {30'b0, mon_e.st});
                chk("stall_cycles", {16'b0, stall_cycles}, {16'b0, mon_e.sc});
            end
        end
    end

    initial begin
        // Reset with a stray ready
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);

        // T1: back-to-back accepts from RESET_PC
        step(0, 0, 0, 0, 1);
        #3 chk("t1_pc0", pc_out, 32'h0);
        chk("t1_st0", {30'b0, fsm_state}, 32'd0);
        chk("t1_sc0", {16'b0, stall_cycles}, 32'd0);
        step(0, 0, 0, 0, 1);
        #3 chk("t1_pc4", pc_out, 32'h4);

        // T2: three slow-memory cycles at pc=8
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #3 chk("t2_wait", {30'b0, fsm_state}, 32'd1);
        chk("t2_addr_held", imem_addr, 32'h8);
        step(0, 0, 0, 0, 1);
        #3 chk("t2_sc3", {16'b0, stall_cycles}, 32'd3);
        chk("t2_latch8", {31'b0, latch_en}, 32'd1);
        chk("t2_pc8", pc_out, 32'h8);
        step(0, 0, 0, 0, 1);
        #3 chk("t1_pcC", pc_out, 32'hC);

        // T3: issue stall with ready at pc=0x10
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        #3 chk("t3_hold", {30'b0, fsm_state}, 32'd2);
        chk("t3_pc_kept", pc_out, 32'h10);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        #3 chk("t3_refetch", imem_addr, 32'h10);
        chk("t3_en", {31'b0, latch_en}, 32'd1);

        // T4: redirect beats a concurrent ready; target alignment
        step(0, 0, 1, 32'h103, 1);
        #3 chk("t4_flush", {31'b0, latch_flush}, 32'd1);
        step(0, 0, 0, 0, 1);
        #3 chk("t4_fst1", {30'b0, fsm_state}, 32'd3);
        step(0, 0, 0, 0, 1);
        #3 chk("t4_fst2", {30'b0, fsm_state}, 32'd3);
        step(0, 0, 0, 0, 1);
        #3 chk("t4_target", imem_addr, 32'h100);
        chk("t4_fetch", {30'b0, fsm_state}, 32'd0);

        // T5: redirect while parked in HOLD with stall still high
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 32'h200, 0);
        #3 chk("t5_en", {31'b0, latch_en}, 32'd1);
        chk("t5_flush", {31'b0, latch_flush}, 32'd1);
        step(0, 1, 0, 0, 0);
        #3 chk("t5_pc", pc_out, 32'h200);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // T6: reset in WAIT with ready, then PC wrap
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        #3 chk("t6_pc", pc_out, 32'h0);
        chk("t6_st", {30'b0, fsm_state}, 32'd0);
        chk("t6_sc", {16'b0, stall_cycles}, 32'd0);
        step(0, 0, 1, 32'hFFFF_FFFE, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        #3 chk("t6_top", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        #3 chk("t6_wrap", pc_out, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        @(negedge clk);
        #4;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
